// File: rtl/gba_sound_psg_mix.sv
// PSG channel mixer: per-side gating, master volume, PSG ratio, decimation.
// Define GBA_PSG_MIX_AVG_EN to box-average frames instead of point sampling.
module gba_sound_psg_mix #(
  parameter int DEC_SHIFT = 4,
  parameter int OUT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gb_on,
  input  logic [15:0]      ch1_in,
  input  logic [15:0]      ch2_in,
  input  logic [15:0]      ch3_in,
  input  logic [15:0]      ch4_in,
  input  logic [3:0]       ch_on,
  input  logic [3:0]       enable_l,
  input  logic [3:0]       enable_r,
  input  logic [2:0]       vol_l,
  input  logic [2:0]       vol_r,
  input  logic [1:0]       psg_ratio,
  output logic [OUT_W-1:0] out_l,
  output logic [OUT_W-1:0] out_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  localparam int MW = 21;
  localparam int CW = (DEC_SHIFT > 0) ? DEC_SHIFT : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << DEC_SHIFT) - 1);
  localparam logic signed [MW-1:0] SMAX = MW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [MW-1:0] SMIN = -SMAX - 1;

  logic                 w_rst;
  logic [15:0]          w_ch;
  logic signed [17:0]   w_term_l;
  logic signed [17:0]   w_term_r;
  logic signed [MW-1:0] w_gain_l;
  logic signed [MW-1:0] w_gain_r;
  logic signed [MW-1:0] w_prod_l;
  logic signed [MW-1:0] w_prod_r;
  logic [1:0]           w_sh;
  logic signed [MW-1:0] w_smp_l;
  logic signed [MW-1:0] w_smp_r;

  logic [1:0]           r_phase;
  logic signed [17:0]   r_sum_l;
  logic signed [17:0]   r_sum_r;
  logic                 r_fv;
  logic signed [MW-1:0] r_mix_l;
  logic signed [MW-1:0] r_mix_r;
  logic                 r_mix_v;
  logic                 r_mix_last;
  logic [CW-1:0]        r_cnt;
  logic [OUT_W-1:0]     r_out_l;
  logic [OUT_W-1:0]     r_out_r;
  logic                 r_out_v;
  logic                 r_ovr;

  assign w_rst = reset | ~gb_on;

  function automatic logic [OUT_W-1:0] f_sat(input logic signed [MW-1:0] v);
    if (v > SMAX) return SMAX[OUT_W-1:0];
    if (v < SMIN) return SMIN[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  // select the channel read in the current phase
  always_comb begin
    w_ch = ch1_in;
    unique case (r_phase)
      2'd0: w_ch = ch1_in;
      2'd1: w_ch = ch2_in;
      2'd2: w_ch = ch3_in;
      2'd3: w_ch = ch4_in;
    endcase
  end

  assign w_term_l = (ch_on[r_phase] & enable_l[r_phase])
                  ? {{2{w_ch[15]}}, w_ch} : '0;
  assign w_term_r = (ch_on[r_phase] & enable_r[r_phase])
                  ? {{2{w_ch[15]}}, w_ch} : '0;

  assign w_gain_l = MW'({1'b0, vol_l} + 4'd1);
  assign w_gain_r = MW'({1'b0, vol_r} + 4'd1);
  assign w_prod_l = MW'(r_sum_l) * w_gain_l;
  assign w_prod_r = MW'(r_sum_r) * w_gain_r;

  // PSG ratio to right-shift amount; code 3 behaves as 25%
  always_comb begin
    w_sh = 2'd2;
    unique case (psg_ratio)
      2'd2:    w_sh = 2'd0;
      2'd1:    w_sh = 2'd1;
      default: w_sh = 2'd2;
    endcase
  end

  // phase counter and per-frame channel sums
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_phase <= '0;
      r_sum_l <= '0;
      r_sum_r <= '0;
      r_fv    <= 1'b0;
    end else begin
      r_phase <= r_phase + 2'd1;
      r_fv    <= (r_phase == 2'd3);
      if (r_phase == 2'd0) begin
        r_sum_l <= w_term_l;
        r_sum_r <= w_term_r;
      end else begin
        r_sum_l <= r_sum_l + w_term_l;
        r_sum_r <= r_sum_r + w_term_r;
      end
    end
  end

  // scale completed frame and track its position in the window
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_mix_l    <= '0;
      r_mix_r    <= '0;
      r_mix_v    <= 1'b0;
      r_mix_last <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_mix_v <= r_fv;
      if (r_fv) begin
        r_mix_l    <= w_prod_l >>> w_sh;
        r_mix_r    <= w_prod_r >>> w_sh;
        r_mix_last <= (r_cnt == LAST);
        r_cnt      <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
      end
    end
  end

`ifdef GBA_PSG_MIX_AVG_EN
  localparam int AW = MW + DEC_SHIFT;

  logic                 r_mix_first;
  logic signed [AW-1:0] r_acc_l;
  logic signed [AW-1:0] r_acc_r;
  logic signed [AW-1:0] w_acc_l;
  logic signed [AW-1:0] w_acc_r;
  logic signed [AW-1:0] w_avg_l;
  logic signed [AW-1:0] w_avg_r;

  assign w_acc_l = (r_mix_first ? '0 : r_acc_l) + AW'(r_mix_l);
  assign w_acc_r = (r_mix_first ? '0 : r_acc_r) + AW'(r_mix_r);
  assign w_avg_l = w_acc_l >>> DEC_SHIFT;
  assign w_avg_r = w_acc_r >>> DEC_SHIFT;
  assign w_smp_l = w_avg_l[MW-1:0];
  assign w_smp_r = w_avg_r[MW-1:0];

  // window accumulator, restarted by the first frame of each window
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_mix_first <= 1'b0;
      r_acc_l     <= '0;
      r_acc_r     <= '0;
    end else begin
      if (r_fv) r_mix_first <= (r_cnt == '0);
      if (r_mix_v) begin
        r_acc_l <= w_acc_l;
        r_acc_r <= w_acc_r;
      end
    end
  end
`else
  assign w_smp_l = r_mix_l;
  assign w_smp_r = r_mix_r;
`endif

  // output register with valid/ready and overrun detection
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_out_l <= '0;
      r_out_r <= '0;
      r_out_v <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (r_mix_v & r_mix_last) begin
      r_out_l <= f_sat(w_smp_l);
      r_out_r <= f_sat(w_smp_r);
      r_out_v <= 1'b1;
      r_ovr   <= r_out_v & ~out_ready;
    end else begin
      r_ovr <= 1'b0;
      if (r_out_v & out_ready) r_out_v <= 1'b0;
    end
  end

  assign out_l     = r_out_l;
  assign out_r     = r_out_r;
  assign out_valid = r_out_v;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_gba_sound_psg_mix.sv
// Bench for gba_sound_psg_mix: directed cases plus random traffic
// checked every clock against a window-level reference model.
module tb_gba_sound_psg_mix;

  localparam int DS   = 2;
  localparam int NF   = 1 << DS;
  localparam int MAXK = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        gb_on = 1'b1;
  logic [15:0] ch [4];
  logic [3:0]  ch_on, enable_l, enable_r;
  logic [2:0]  vol_l, vol_r;
  logic [1:0]  psg_ratio;
  logic        out_ready;
  logic [15:0] out_l, out_r;
  logic        out_valid, overrun;

  gba_sound_psg_mix #(.DEC_SHIFT(DS), .OUT_W(16)) dut (
    .clk(clk), .reset(reset), .gb_on(gb_on),
    .ch1_in(ch[0]), .ch2_in(ch[1]), .ch3_in(ch[2]), .ch4_in(ch[3]),
    .ch_on(ch_on), .enable_l(enable_l), .enable_r(enable_r),
    .vol_l(vol_l), .vol_r(vol_r), .psg_ratio(psg_ratio),
    .out_l(out_l), .out_r(out_r), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // per-clock record since the last reset: gated contributions and controls
  int cl [MAXK];
  int cr [MAXK];
  int vl [MAXK];
  int vr [MAXK];
  int rt [MAXK];
  int k;
  int exp_l, exp_r;
  bit exp_v, exp_ov;
  bit alt_mode;
  int checks, failures;

  task automatic chk(string tag, int obs, int expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, expv);
    end
  endtask

  function automatic int sat16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // frame f covers clocks 4f..4f+3; it is scaled with the controls at 4f+4
  function automatic int frame_mix(int f, bit right);
    int s, v, r, sh;
    s = 0;
    for (int i = 0; i < 4; i++) s += right ? cr[4*f+i] : cl[4*f+i];
    v  = right ? vr[4*f+4] : vl[4*f+4];
    r  = rt[4*f+4];
    sh = (r == 2) ? 0 : (r == 1) ? 1 : 2;
    return (s * (v + 1)) >>> sh;
  endfunction

  function automatic int window_sample(int w, bit right);
`ifdef GBA_PSG_MIX_AVG_EN
    int a;
    a = 0;
    for (int j = 0; j < NF; j++) a += frame_mix(w*NF + j, right);
    return sat16(a >>> DS);
`else
    return sat16(frame_mix(w*NF + NF - 1, right));
`endif
  endfunction

  // advance one clock, update the reference, compare all outputs
  task automatic step();
    int p, w;
    if (alt_mode) ch[0] = ((k / 4) % 2 == 1) ? 16'hFFF1 : 16'd15;
    @(posedge clk);
    if (reset || !gb_on) begin
      k = 0; exp_l = 0; exp_r = 0; exp_v = 0; exp_ov = 0;
    end else begin
      if (k >= MAXK) begin
        $display("FAIL model_depth got=%0d exp=<%0d", k, MAXK);
        $fatal(1, "model depth exceeded");
      end
      p = k % 4;
      cl[k] = (ch_on[p] && enable_l[p]) ? int'($signed(ch[p])) : 0;
      cr[k] = (ch_on[p] && enable_r[p]) ? int'($signed(ch[p])) : 0;
      vl[k] = int'(vol_l);
      vr[k] = int'(vol_r);
      rt[k] = int'(psg_ratio);
      if (k >= 5 && (k - 1) % (4*NF) == 0) begin
        w = (k - 1) / (4*NF) - 1;
        exp_ov = exp_v && !out_ready;
        exp_v  = 1;
        exp_l  = window_sample(w, 0);
        exp_r  = window_sample(w, 1);
      end else begin
        exp_ov = 0;
        if (exp_v && out_ready) exp_v = 0;
      end
      k++;
    end
    #1;
    chk("out_l", int'($signed(out_l)), exp_l);
    chk("out_r", int'($signed(out_r)), exp_r);
    chk("out_valid", int'(out_valid), int'(exp_v));
    chk("overrun", int'(overrun), int'(exp_ov));
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!out_valid && n < maxc);
    if (!out_valid) chk("wait_timeout", 0, 1);
  endtask

  task automatic simple_src(input logic [15:0] v);
    ch[0] = v; ch[1] = 0; ch[2] = 0; ch[3] = 0;
    ch_on = 4'b0001; enable_l = 4'b0001; enable_r = 4'b0000;
  endtask

  initial begin
    int n, held, ovc;
    checks = 0; failures = 0; k = 0; alt_mode = 0;
    exp_l = 0; exp_r = 0; exp_v = 0; exp_ov = 0;
    simple_src(16'd15);
    vol_l = 3'd7; vol_r = 3'd7; psg_ratio = 2'd2; out_ready = 1'b1;
    #1;
    step(); step();
    reset = 1'b0;

    wait_valid(40, n);
    chk("first_rise_clk", n - 1, 17);
    chk("scale_r2_l", int'($signed(out_l)), 120);
    chk("scale_r2_r", int'($signed(out_r)), 0);
    wait_valid(40, n);
    chk("period", n, 16);
    step();
    chk("valid_drop", int'(out_valid), 0);

    psg_ratio = 2'd1; wait_valid(40, n); wait_valid(40, n);
    chk("scale_r1", int'($signed(out_l)), 60);
    psg_ratio = 2'd0; wait_valid(40, n); wait_valid(40, n);
    chk("scale_r0", int'($signed(out_l)), 30);
    psg_ratio = 2'd3; wait_valid(40, n); wait_valid(40, n);
    chk("scale_r3", int'($signed(out_l)), 30);

    psg_ratio = 2'd2;
    for (int i = 0; i < 4; i++) ch[i] = 16'h7FFF;
    ch_on = 4'hF; enable_l = 4'hF; enable_r = 4'hF;
    wait_valid(40, n); wait_valid(40, n);
    chk("sat_pos_l", int'($signed(out_l)), 32767);
    chk("sat_pos_r", int'($signed(out_r)), 32767);
    for (int i = 0; i < 4; i++) ch[i] = 16'h8000;
    wait_valid(40, n); wait_valid(40, n);
    chk("sat_neg_l", int'($signed(out_l)), -32768);
    chk("sat_neg_r", int'($signed(out_r)), -32768);

    ch_on = 4'h0;
    wait_valid(40, n); wait_valid(40, n);
    chk("gated_l", int'($signed(out_l)), 0);
    chk("gated_r", int'($signed(out_r)), 0);

    simple_src(16'd15);
    out_ready = 1'b0;
    wait_valid(40, n);
    ch[0] = 16'd40;
    held = 1; ovc = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (!out_valid) held = 0;
      if (overrun) ovc++;
    end
    chk("hold_valid", held, 1);
    chk("overrun_once", ovc, 1);
    out_ready = 1'b1;
    step();
    chk("drop_after_xfer", int'(out_valid), 0);

    vol_l = 3'd0; psg_ratio = 2'd2; alt_mode = 1;
    wait_valid(40, n); wait_valid(40, n);
`ifdef GBA_PSG_MIX_AVG_EN
    chk("avg_alt", int'($signed(out_l)), 0);
`else
    chk("point_alt", int'($signed(out_l)), -15);
`endif
    alt_mode = 0;

    out_ready = 1'b0;
    wait_valid(40, n);
    step(); step(); step();
    gb_on = 1'b0;
    step();
    chk("gb_off_valid", int'(out_valid), 0);
    gb_on = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      for (int j = 0; j < 4; j++) ch[j] = 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        ch_on = 4'($urandom); enable_l = 4'($urandom);
        enable_r = 4'($urandom); vol_l = 3'($urandom);
        vol_r = 3'($urandom); psg_ratio = 2'($urandom);
      end
      out_ready = 1'($urandom);
      gb_on = ($urandom_range(0, 199) != 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
